// File: rtl/rv_pipe_pkg.sv
// rtl/rv_pipe_pkg.sv - shared pipeline types for the hazard scoreboard
package rv_pipe_pkg;

  localparam int HZ_RA_W = 5;
  localparam int FWD_RF  = 0;

  typedef struct packed {
    logic               valid;
    logic [HZ_RA_W-1:0] rda;
    logic               rfwe;
    logic               load;
  } hz_entry_t;

endpackage

// File: rtl/rv_fwd_pick.sv
// rtl/rv_fwd_pick.sv - youngest-match forwarding select for one source operand
module rv_fwd_pick
  import rv_pipe_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int RA_W       = HZ_RA_W,
  parameter int NSTAGES    = 3,
  parameter int LOAD_STAGE = 1,
  parameter int SEL_W      = $clog2(NSTAGES + 1)
) (
  input  hz_entry_t [NSTAGES-1:0]   entries_i,
  input  logic [NSTAGES*XLEN-1:0]   stage_data_i,
  input  logic [RA_W-1:0]           rsa_i,
  input  logic                      jump_i,
  output logic [SEL_W-1:0]          sel_o,
  output logic [XLEN-1:0]           data_o,
  output logic                      hazard_o
);

  // Walk oldest to youngest so the lowest-index match overwrites any older one.
  always_comb begin
    sel_o    = SEL_W'(FWD_RF);
    data_o   = '0;
    hazard_o = 1'b0;
    for (int k = NSTAGES - 1; k >= 0; k--) begin
      if (entries_i[k].valid && entries_i[k].rfwe &&
          (entries_i[k].rda == rsa_i) && (rsa_i != '0)) begin
        if (entries_i[k].load ? (k >= LOAD_STAGE) : (jump_i ? (k >= 1) : 1'b1)) begin
          sel_o    = SEL_W'(k + 1);
          data_o   = stage_data_i[k*XLEN +: XLEN];
          hazard_o = 1'b0;
        end else begin
          sel_o    = SEL_W'(FWD_RF);
          data_o   = '0;
          hazard_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rv_hazard_scoreboard.sv
// rtl/rv_hazard_scoreboard.sv - in-flight destination scoreboard with forwarding and stall control
module rv_hazard_scoreboard
  import rv_pipe_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int RA_W       = HZ_RA_W,
  parameter int NSTAGES    = 3,
  parameter int LOAD_STAGE = 1,
  parameter int CNT_W      = 16,
  parameter int SEL_W      = $clog2(NSTAGES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ex_stall,
  input  logic                    i_flush,
  input  logic                    i_d_valid,
  input  logic [RA_W-1:0]         i_d_rs1a,
  input  logic [RA_W-1:0]         i_d_rs2a,
  input  logic [RA_W-1:0]         i_d_rda,
  input  logic                    i_d_rfwe,
  input  logic                    i_d_load,
  input  logic                    i_d_jump,
  input  logic [NSTAGES*XLEN-1:0] i_stage_data,
  output logic [SEL_W-1:0]        o_fwd1_sel,
  output logic [SEL_W-1:0]        o_fwd2_sel,
  output logic [XLEN-1:0]         o_fwd1_data,
  output logic [XLEN-1:0]         o_fwd2_data,
  output logic                    o_stall,
  output logic [CNT_W-1:0]        o_stall_cnt
);

  hz_entry_t [NSTAGES-1:0] entries_q, entries_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  hz_entry_t               dec_entry;
  logic                    haz1, haz2;

  rv_fwd_pick #(
    .XLEN(XLEN), .RA_W(RA_W), .NSTAGES(NSTAGES), .LOAD_STAGE(LOAD_STAGE), .SEL_W(SEL_W)
  ) u_pick_rs1 (
    .entries_i    (entries_q),
    .stage_data_i (i_stage_data),
    .rsa_i        (i_d_rs1a),
    .jump_i       (i_d_jump),
    .sel_o        (o_fwd1_sel),
    .data_o       (o_fwd1_data),
    .hazard_o     (haz1)
  );

  rv_fwd_pick #(
    .XLEN(XLEN), .RA_W(RA_W), .NSTAGES(NSTAGES), .LOAD_STAGE(LOAD_STAGE), .SEL_W(SEL_W)
  ) u_pick_rs2 (
    .entries_i    (entries_q),
    .stage_data_i (i_stage_data),
    .rsa_i        (i_d_rs2a),
    .jump_i       (i_d_jump),
    .sel_o        (o_fwd2_sel),
    .data_o       (o_fwd2_data),
    .hazard_o     (haz2)
  );

  assign o_stall     = i_d_valid & ~i_flush & (haz1 | haz2);
  assign o_stall_cnt = cnt_q;

  always_comb begin
    dec_entry       = '0;
    dec_entry.valid = 1'b1;
    dec_entry.rda   = i_d_rda;
    dec_entry.rfwe  = i_d_rfwe;
    dec_entry.load  = i_d_load;
    entries_d       = entries_q;
    cnt_d           = cnt_q;
    // An external stall freezes everything, including a pending hazard's bubble and count.
    if (!ex_stall) begin
      for (int k = NSTAGES - 1; k >= 1; k--) begin
        entries_d[k] = entries_q[k-1];
      end
      entries_d[0] = (o_stall || i_flush || !i_d_valid) ? '0 : dec_entry;
      if (o_stall && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entries_q <= '0;
      cnt_q     <= '0;
    end else begin
      entries_q <= entries_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rv_hazard_scoreboard.sv
// tb/tb_rv_hazard_scoreboard.sv - directed self-checking bench for rv_hazard_scoreboard
module tb_rv_hazard_scoreboard;

  localparam int XLEN  = 32;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             ex_stall;
  logic             i_flush;
  logic             i_d_valid;
  logic [4:0]       i_d_rs1a, i_d_rs2a, i_d_rda;
  logic             i_d_rfwe, i_d_load, i_d_jump;
  logic [3*XLEN-1:0] i_stage_data;
  logic [1:0]       o_fwd1_sel, o_fwd2_sel;
  logic [XLEN-1:0]  o_fwd1_data, o_fwd2_data;
  logic             o_stall;
  logic [CNT_W-1:0] o_stall_cnt;

  int checks   = 0;
  int failures = 0;

  rv_hazard_scoreboard #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_stall     (ex_stall),
    .i_flush      (i_flush),
    .i_d_valid    (i_d_valid),
    .i_d_rs1a     (i_d_rs1a),
    .i_d_rs2a     (i_d_rs2a),
    .i_d_rda      (i_d_rda),
    .i_d_rfwe     (i_d_rfwe),
    .i_d_load     (i_d_load),
    .i_d_jump     (i_d_jump),
    .i_stage_data (i_stage_data),
    .o_fwd1_sel   (o_fwd1_sel),
    .o_fwd2_sel   (o_fwd2_sel),
    .o_fwd1_data  (o_fwd1_data),
    .o_fwd2_data  (o_fwd2_data),
    .o_stall      (o_stall),
    .o_stall_cnt  (o_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic dec(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic we, input logic ld, input logic jp);
    i_d_valid = v;
    i_d_rs1a  = rs1;
    i_d_rs2a  = rs2;
    i_d_rda   = rd;
    i_d_rfwe  = we;
    i_d_load  = ld;
    i_d_jump  = jp;
  endtask

  task automatic drain();
    dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
  endtask

  initial begin
    rst          = 1'b1;
    ex_stall     = 1'b0;
    i_flush      = 1'b0;
    i_stage_data = {32'h0000_00CC, 32'h0000_0022, 32'h0000_0011};
    dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    rst = 1'b0;

    // Reset / idle: a decode reading x5 finds nothing in flight
    dec(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("reset_sel1", o_fwd1_sel, 0);
    chk("reset_data1", o_fwd1_data, 0);
    chk("reset_stall", o_stall, 0);
    chk("reset_cnt", o_stall_cnt, 0);
    drain();

    // ALU back-to-back on x5
    dec(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    dec(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("alu_sel1", o_fwd1_sel, 1);
    chk("alu_data1", o_fwd1_data, 32'h11);
    chk("alu_sel2", o_fwd2_sel, 1);
    chk("alu_stall", o_stall, 0);
    drain();

    // Load-use on x7 via rs2
    dec(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    dec(1'b1, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("ld_stall", o_stall, 1);
    chk("ld_sel2_stall", o_fwd2_sel, 0);
    chk("ld_data2_stall", o_fwd2_data, 0);
    tick();
    chk("ld_stall_after", o_stall, 0);
    chk("ld_sel2", o_fwd2_sel, 2);
    chk("ld_data2", o_fwd2_data, 32'h22);
    chk("ld_cnt", o_stall_cnt, 1);
    drain();

    // Branch needs x3 in decode: ALU result in E is too late
    dec(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    dec(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    settle();
    chk("br_stall", o_stall, 1);
    chk("br_sel1_stall", o_fwd1_sel, 0);
    tick();
    chk("br_stall_after", o_stall, 0);
    chk("br_sel1", o_fwd1_sel, 2);
    chk("br_cnt", o_stall_cnt, 2);
    drain();

    // Branch reading x0 while E "writes" x0: never a match
    dec(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    dec(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    settle();
    chk("x0_stall", o_stall, 0);
    chk("x0_sel1", o_fwd1_sel, 0);
    drain();

    // Priority: E=x9, M=x1, W=x9
    i_stage_data = {32'h0000_00BB, 32'h0000_0022, 32'h0000_00AA};
    dec(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
    tick();
    dec(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0);
    tick();
    dec(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
    tick();
    dec(1'b1, 5'd9, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("pri_sel1", o_fwd1_sel, 1);
    chk("pri_data1", o_fwd1_data, 32'hAA);
    chk("pri_sel2", o_fwd2_sel, 2);
    chk("pri_data2", o_fwd2_data, 32'h22);
    drain();
    i_stage_data = {32'h0000_00CC, 32'h0000_0022, 32'h0000_0011};

    // ex_stall held across a load-use stall
    dec(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    dec(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    ex_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("exs_stall_held", o_stall, 1);
      chk("exs_cnt_frozen", o_stall_cnt, 2);
    end
    ex_stall = 1'b0;
    tick();
    chk("exs_cnt", o_stall_cnt, 3);
    chk("exs_stall_after", o_stall, 0);
    chk("exs_sel1", o_fwd1_sel, 2);
    drain();

    // Flush alongside a load-use hazard: no stall, bubble enters E
    dec(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    dec(1'b1, 5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
    i_flush = 1'b1;
    settle();
    chk("fl_stall", o_stall, 0);
    tick();
    i_flush = 1'b0;
    dec(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("fl_bubble_sel1", o_fwd1_sel, 2);
    chk("fl_cnt", o_stall_cnt, 3);
    drain();

    // Reset in the middle of a stall
    dec(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    dec(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("rst_pre_stall", o_stall, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("rst_stall", o_stall, 0);
    chk("rst_cnt", o_stall_cnt, 0);
    drain();

    // Counter saturation: nine one-cycle load-use stalls into a 3-bit counter
    for (int i = 0; i < 9; i++) begin
      dec(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
      tick();
      dec(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    settle();
    chk("sat_cnt", o_stall_cnt, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
